// File: rtl/mdp_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, FSM states and
// instruction field positions.
package mdp_pkg;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpXor  = 4'h5;
    localparam logic [3:0] OpAddi = 4'h6;
    localparam logic [3:0] OpLdi  = 4'h7;
    localparam logic [3:0] OpLd   = 4'h8;
    localparam logic [3:0] OpSt   = 4'h9;
    localparam logic [3:0] OpJmp  = 4'hA;
    localparam logic [3:0] OpBeqz = 4'hB;
    localparam logic [3:0] OpHalt = 4'hC;

    localparam int unsigned InstrW    = 16;
    localparam int unsigned OpcodeLsb = 12;
    localparam int unsigned RdLsb     = 8;
    localparam int unsigned RsLsb     = 4;
    localparam int unsigned ImmLsb    = 0;
    localparam int unsigned FieldW    = 4;
    localparam int unsigned ImmW      = 8;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMem,
        StWb,
        StHalted
    } mdp_state_e;

endpackage

// File: rtl/mdp_regfile.sv
// Register file: NUM_REGS x DATA_W, two asynchronous read ports, one
// synchronous write port, asynchronous active-low clear.
module mdp_regfile #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle CPU datapath: FETCH/EXEC/MEM/WB/HALTED FSM, decode and ALU.
// Define MDP_BRANCH_EN to implement BEQZ; otherwise opcode B is illegal.
module multicycle_datapath
    import mdp_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] result_out,
    output logic              instr_done,
    output logic              illegal,
    output logic              halted
);

    localparam int unsigned RegIdxW = $clog2(NUM_REGS);

    mdp_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, next_pc_q, next_pc_d, mem_addr_q, mem_addr_d;
    logic [InstrW-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] wb_val_q, wb_val_d, mem_wdata_q, mem_wdata_d, result_q, result_d;
    logic              wb_en_q, wb_en_d, mem_we_q, mem_we_d, illegal_q, illegal_d;

    logic [3:0]         opcode;
    logic [RegIdxW-1:0] rd_idx, rs_idx;
    logic [ImmW-1:0]    imm8;
    logic [DATA_W-1:0]  imm_data, rd_val, rs_val;
    logic [ADDR_W-1:0]  imm_addr;
    logic               rf_we;
    logic               unused_reg_fields;

    assign opcode   = ir_q[OpcodeLsb +: FieldW];
    assign rd_idx   = ir_q[RdLsb +: RegIdxW];
    assign rs_idx   = ir_q[RsLsb +: RegIdxW];
    assign imm8     = ir_q[ImmLsb +: ImmW];
    assign imm_data = DATA_W'(imm8);
    assign imm_addr = ADDR_W'(imm8);
    // Register fields wider than the index are ignored by design.
    assign unused_reg_fields = ^ir_q[RdLsb +: FieldW];

    assign rf_we = (state_q == StWb) && wb_en_q;

    mdp_regfile #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .IDX_W   (RegIdxW)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset),
        .raddr_a_i(rd_idx),
        .rdata_a_o(rd_val),
        .raddr_b_i(rs_idx),
        .rdata_b_o(rs_val),
        .we_i     (rf_we),
        .waddr_i  (rd_idx),
        .wdata_i  (wb_val_q)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        wb_val_d    = wb_val_q;
        mem_wdata_d = mem_wdata_q;
        result_d    = result_q;
        wb_en_d     = wb_en_q;
        mem_we_d    = mem_we_q;
        illegal_d   = illegal_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d     = StWb;
                next_pc_d   = pc_q + ADDR_W'(1);
                wb_en_d     = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = ADDR_W'(rs_val);
                mem_wdata_d = rd_val;
                case (opcode)
                    OpNop: ;
                    OpAdd: begin wb_en_d = 1'b1; wb_val_d = rd_val + rs_val;   end
                    OpSub: begin wb_en_d = 1'b1; wb_val_d = rd_val - rs_val;   end
                    OpAnd: begin wb_en_d = 1'b1; wb_val_d = rd_val & rs_val;   end
                    OpOr:  begin wb_en_d = 1'b1; wb_val_d = rd_val | rs_val;   end
                    OpXor: begin wb_en_d = 1'b1; wb_val_d = rd_val ^ rs_val;   end
                    OpAddi: begin wb_en_d = 1'b1; wb_val_d = rd_val + imm_data; end
                    OpLdi: begin wb_en_d = 1'b1; wb_val_d = imm_data;          end
                    OpLd:  begin wb_en_d = 1'b1; state_d = StMem;              end
                    OpSt:  begin mem_we_d = 1'b1; state_d = StMem;             end
                    OpJmp: next_pc_d = imm_addr;
`ifdef MDP_BRANCH_EN
                    OpBeqz: begin
                        if (rd_val == '0) begin
                            next_pc_d = imm_addr;
                        end
                    end
`endif
                    OpHalt: state_d = StHalted;
                    default: illegal_d = 1'b1;
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = StWb;
                    if (!mem_we_q) begin
                        wb_val_d = dmem_rdata;
                    end
                end
            end
            StWb: begin
                pc_d    = next_pc_q;
                state_d = StFetch;
                if (wb_en_q) begin
                    result_d = wb_val_q;
                end
            end
            StHalted: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            next_pc_q   <= '0;
            mem_addr_q  <= '0;
            ir_q        <= '0;
            wb_val_q    <= '0;
            mem_wdata_q <= '0;
            result_q    <= '0;
            wb_en_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            next_pc_q   <= next_pc_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            wb_val_q    <= wb_val_d;
            mem_wdata_q <= mem_wdata_d;
            result_q    <= result_d;
            wb_en_q     <= wb_en_d;
            mem_we_q    <= mem_we_d;
            illegal_q   <= illegal_d;
        end
    end

    // Gating with reset keeps the fetch request low while reset is held and
    // lets it rise in the very first cycle after release.
    assign imem_req   = reset && (state_q == StFetch);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = mem_we_q;
    assign dmem_addr  = mem_addr_q;
    assign dmem_wdata = mem_wdata_q;
    assign pc_out     = pc_q;
    assign result_out = result_q;
    assign instr_done = (state_q == StWb);
    assign illegal    = illegal_q;
    assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: instruction-level model plus
// directed programs and randomized programs with random memory wait states.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [7:0]  pc_out, result_out;
    logic        instr_done, illegal, halted;

    multicycle_datapath #(
        .DATA_W  (8),
        .NUM_REGS(4),
        .ADDR_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .pc_out    (pc_out),
        .result_out(result_out),
        .instr_done(instr_done),
        .illegal   (illegal),
        .halted    (halted)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    bit chk_en = 1'b0;

    logic [15:0] imem [256];
    logic [7:0]  dev_dmem [256];
    logic [7:0]  m_dmem [256];

    logic [7:0] m_pc, m_result;
    logic [7:0] m_regs [4];
    logic       m_illegal, m_halted;

    int max_iw = 0, max_dw = 0, fix_dw = -1;
    bit noise = 1'b0;

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_result = 8'h00;
        m_illegal = 1'b0;
        m_halted = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    endtask

    // Executes one instruction at ISA level.
    task automatic model_step(input logic [15:0] ins);
        logic [3:0] op;
        logic [7:0] a, b, imm, npc, v;
        int rd, rs;
        bit wr;
        op  = ins[15:12];
        rd  = int'(ins[9:8]);
        rs  = int'(ins[5:4]);
        imm = ins[7:0];
        a   = m_regs[rd];
        b   = m_regs[rs];
        npc = m_pc + 8'd1;
        wr  = 1'b1;
        v   = 8'h00;
        case (op)
            4'h1: v = a + b;
            4'h2: v = a - b;
            4'h3: v = a & b;
            4'h4: v = a | b;
            4'h5: v = a ^ b;
            4'h6: v = a + imm;
            4'h7: v = imm;
            4'h8: v = m_dmem[b];
            4'h9: begin m_dmem[b] = a; wr = 1'b0; end
            4'hA: begin npc = imm; wr = 1'b0; end
            4'hB: begin
                wr = 1'b0;
`ifdef MDP_BRANCH_EN
                if (a == 8'h00) npc = imm;
`else
                m_illegal = 1'b1;
`endif
            end
            4'h0: wr = 1'b0;
            default: begin m_illegal = 1'b1; wr = 1'b0; end
        endcase
        if (wr) begin
            m_regs[rd] = v;
            m_result = v;
        end
        m_pc = npc;
    endtask

    // Memory responders with configurable wait states.
    initial begin : responders
        bit i_busy, d_busy;
        int i_cnt, d_cnt;
        i_busy = 0; d_busy = 0; i_cnt = 0; d_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                imem_ready = 1'b0;
                dmem_ready = 1'b0;
                i_busy = 0;
                d_busy = 0;
            end else begin
                if (imem_req) begin
                    if (!i_busy) begin
                        i_busy = 1;
                        i_cnt = $urandom_range(max_iw, 0);
                    end
                    if (i_cnt == 0) begin
                        imem_ready = 1'b1;
                        imem_rdata = imem[imem_addr];
                    end else begin
                        imem_ready = 1'b0;
                        imem_rdata = 16'($urandom);
                        i_cnt--;
                    end
                end else begin
                    i_busy = 0;
                    imem_ready = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                    imem_rdata = 16'($urandom);
                end
                if (dmem_req) begin
                    if (!d_busy) begin
                        d_busy = 1;
                        d_cnt = (fix_dw >= 0) ? fix_dw : $urandom_range(max_dw, 0);
                    end
                    if (d_cnt == 0) begin
                        dmem_ready = 1'b1;
                        if (dmem_we) dev_dmem[dmem_addr] = dmem_wdata;
                        else dmem_rdata = dev_dmem[dmem_addr];
                    end else begin
                        dmem_ready = 1'b0;
                        dmem_rdata = 8'($urandom);
                        d_cnt--;
                    end
                end else begin
                    d_busy = 0;
                    dmem_ready = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                    dmem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Compare process: DUT against the instruction-level model every cycle.
    initial begin : compare
        logic [15:0] ins;
        forever begin
            @(negedge clk);
            if (reset && chk_en) begin
                if (m_halted) begin
                    chk("halt_stays", {imem_req, dmem_req, instr_done, halted}, 4'b0001);
                end else begin
                    chk("pc", pc_out, m_pc);
                    chk("result", result_out, m_result);
                    if (imem_req) chk("fetch_addr", imem_addr, m_pc);
                    if (dmem_req) begin
                        ins = imem[m_pc];
                        chk("dmem_we", dmem_we, ins[15:12] == 4'h9);
                        chk("dmem_addr", dmem_addr, m_regs[ins[5:4]]);
                        if (ins[15:12] == 4'h9) chk("dmem_wdata", dmem_wdata, m_regs[ins[9:8]]);
                    end
                    if (instr_done) begin
                        model_step(imem[m_pc]);
                        chk("illegal", illegal, m_illegal);
                    end
                    if (halted) begin
                        ins = imem[m_pc];
                        chk("halt_op", ins[15:12], 4'hC);
                        chk("halt_illegal", illegal, m_illegal);
                        m_halted = 1'b1;
                    end
                end
            end
        end
    end

    task automatic assert_reset();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        rel = cyc;
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halted", halted, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0, d1, hs, req_after, sc, reqn, bad_addr, early, ndone, n;
        logic [7:0] fa [$];
        bit prev_req;
        for (int i = 0; i < 256; i++) begin
            dev_dmem[i] = 8'h00;
            m_dmem[i] = 8'h00;
        end
        fill_imem();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {imem_req, dmem_req, dmem_we, instr_done, illegal, halted}, 6'b0);
        chk("reset_data", {imem_addr, dmem_addr, dmem_wdata, pc_out, result_out}, 40'h0);
        chk_en = 1'b1;

        // LDI r1,5; ADDI r1,3; HALT with zero-wait memory.
        imem[0] = 16'h7105; imem[1] = 16'h6103; imem[2] = 16'hC000;
        release_reset();
        d0 = -1; d1 = -1; hs = -1; req_after = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            sc = cyc - rel + 1;
            if (instr_done) begin
                if (d0 < 0) d0 = sc;
                else if (d1 < 0) d1 = sc;
            end
            if (halted && hs < 0) hs = sc;
            if (sc >= 9 && imem_req) req_after++;
        end
        chk("done1_cycle", d0, 3);
        chk("done2_cycle", d1, 6);
        chk("halt_cycle", hs, 9);
        chk("req_after_halt", req_after, 0);
        chk("ldi_addi_result", result_out, 8'h08);

        // SUB wrap.
        assert_reset(); fill_imem();
        imem[0] = 16'h7101; imem[1] = 16'h2010;
        release_reset();
        wait_halt(50);
        chk("sub_wrap", result_out, 8'hFF);

        // LD with three wait cycles.
        assert_reset(); fill_imem();
        imem[0] = 16'h7240; imem[1] = 16'h8320;
        dev_dmem[8'h40] = 8'hA5; m_dmem[8'h40] = 8'hA5;
        fix_dw = 3;
        release_reset();
        reqn = 0; bad_addr = 0; early = 0; n = 0;
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
            if (dmem_req) begin
                reqn++;
                if (dmem_addr != 8'h40) bad_addr++;
                if (result_out == 8'hA5) early++;
            end
        end
        fix_dw = -1;
        chk("ld_req_cycles", reqn, 4);
        chk("ld_addr_bad", bad_addr, 0);
        chk("ld_early_result", early, 0);
        chk("ld_result", result_out, 8'hA5);

        // BEQZ taken/not-taken.
        assert_reset(); fill_imem();
        imem[0] = 16'hB220;
        release_reset();
        wait_halt(50);
`ifdef MDP_BRANCH_EN
        chk("beqz_zero_pc", pc_out, 8'h20);
        chk("beqz_zero_illegal", illegal, 1'b0);
`else
        chk("beqz_zero_pc", pc_out, 8'h01);
        chk("beqz_zero_illegal", illegal, 1'b1);
`endif
        assert_reset(); fill_imem();
        imem[0] = 16'h7207; imem[1] = 16'hB220;
        release_reset();
        wait_halt(50);
        chk("beqz_nz_pc", pc_out, 8'h02);
`ifdef MDP_BRANCH_EN
        chk("beqz_nz_illegal", illegal, 1'b0);
`else
        chk("beqz_nz_illegal", illegal, 1'b1);
`endif

        // PC wrap from 0xFF.
        assert_reset(); fill_imem();
        imem[0] = 16'hA0FF; imem[8'hFF] = 16'h0000;
        release_reset();
        fa.delete();
        prev_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req && !prev_req) fa.push_back(imem_addr);
            prev_req = imem_req;
        end
        chk("wrap_fetch_count", fa.size() >= 3, 1'b1);
        if (fa.size() >= 3) begin
            chk("wrap_fetch_ff", fa[1], 8'hFF);
            chk("wrap_fetch_00", fa[2], 8'h00);
        end

        // Illegal opcode is sticky.
        assert_reset(); fill_imem();
        imem[0] = 16'hE000; imem[1] = 16'h0000;
        release_reset();
        wait_halt(50);
        chk("illegal_sticky", illegal, 1'b1);

        // Reset during a MEM wait.
        assert_reset(); fill_imem();
        imem[0] = 16'h8000;
        fix_dw = 6;
        release_reset();
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_wait_reached", dmem_req, 1'b1);
        #2 assert_reset();
        #1;
        chk("abort_ctrl", {imem_req, dmem_req, dmem_we, instr_done, illegal, halted}, 6'b0);
        chk("abort_data", {imem_addr, dmem_addr, dmem_wdata, pc_out, result_out}, 40'h0);
        fix_dw = -1;
        release_reset();
        @(negedge clk);
        chk("refetch", {imem_req, imem_addr}, 9'h100);
        wait_halt(60);

        // Randomized programs, two rounds.
        for (int round = 0; round < 2; round++) begin
            assert_reset();
            for (int i = 0; i < 256; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(15, 0));
                if (op == 4'hC) op = 4'h0;
                imem[i] = {op, 12'($urandom)};
                dev_dmem[i] = 8'($urandom);
                m_dmem[i] = dev_dmem[i];
            end
            max_iw = 2; max_dw = 3; noise = (round == 1);
            release_reset();
            ndone = 0; n = 0;
            while (ndone < 400 && n < 8000) begin
                @(negedge clk);
                n++;
                if (instr_done) ndone++;
            end
            chk("random_retired", ndone, 400);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
